// File: rtl/life_game_step_ctrl.sv
// life_game_step_ctrl: one-generation Conway (B3/S23) stepper for a toroidal
// grid of ROWS x 32 cells, one row per memory word. Owns the single port of
// the cell memory and shares it with the CPU, which always wins arbitration.
// The engine streams rows through three registers (up/cur/dn) and writes each
// new row back in place. Row 0's original contents are saved in save0 so that
// the last row can still see the old row 0 after it has been overwritten.
module life_game_step_ctrl #(
    parameter int ROWS = 32,
    parameter int AW   = 7,
    parameter int GW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [GW-1:0] gen_count,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [AW-1:0] LAST_ROW   = AW'(ROWS - 1);
    localparam logic [AW-1:0] PENULT_ROW = AW'(ROWS - 2);
    localparam logic [AW-1:0] ROW_ONE    = AW'(1);
    localparam logic [GW-1:0] GEN_ONE    = GW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISS,
        S_RD_CAP,
        S_WR,
        S_DONE
    } state_t;

    // LAST/FIRST preload the wrap-around neighbour and row 0; LOOP streams the rest.
    typedef enum logic [1:0] {
        PH_LAST,
        PH_FIRST,
        PH_LOOP
    } phase_t;

    state_t        state;
    phase_t        phase;
    logic [AW-1:0] row;
    logic [31:0]   up;
    logic [31:0]   cur;
    logic [31:0]   dn;
    logic [31:0]   save0;
    logic [31:0]   next_row;

    // Per-column neighbour count with horizontal wrap; column 31 touches column 0.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_cell
            localparam int LC = (gi + 31) % 32;
            localparam int RC = (gi + 1) % 32;
            logic [3:0] nbrs;
            assign nbrs = {3'b000, up[LC]}  + {3'b000, up[gi]} + {3'b000, up[RC]}
                        + {3'b000, cur[LC]} + {3'b000, cur[RC]}
                        + {3'b000, dn[LC]}  + {3'b000, dn[gi]} + {3'b000, dn[RC]};
            assign next_row[gi] = (nbrs == 4'd3) || ((nbrs == 4'd2) && cur[gi]);
        end
    endgenerate

    assign cpu_rdata = mem_rdata;

    // Memory port mux: CPU first, otherwise the engine's read/write address.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = row;
        mem_wdata = next_row;
        if (cpu_req) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else begin
            // Gating with rst keeps a reset cycle that lands on WR from writing.
            mem_we = rst && (state == S_WR);
            if (state == S_RD_ISS) begin
                case (phase)
                    PH_LAST:  mem_addr = LAST_ROW;
                    PH_FIRST: mem_addr = '0;
                    default:  mem_addr = row + ROW_ONE;
                endcase
            end
        end
    end

    // Step sequencer: preload, then read-ahead / write-behind one row at a time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            phase     <= PH_LAST;
            row       <= '0;
            up        <= '0;
            cur       <= '0;
            dn        <= '0;
            save0     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gen_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        phase <= PH_LAST;
                        busy  <= 1'b1;
                        state <= S_RD_ISS;
                    end
                end
                S_RD_ISS: begin
                    if (!cpu_req) begin
                        state <= S_RD_CAP;
                    end
                end
                S_RD_CAP: begin
                    // Data belongs to the address issued last cycle, so no stall here.
                    case (phase)
                        PH_LAST: begin
                            up    <= mem_rdata;
                            phase <= PH_FIRST;
                            state <= S_RD_ISS;
                        end
                        PH_FIRST: begin
                            cur   <= mem_rdata;
                            save0 <= mem_rdata;
                            row   <= '0;
                            phase <= PH_LOOP;
                            state <= S_RD_ISS;
                        end
                        default: begin
                            dn    <= mem_rdata;
                            state <= S_WR;
                        end
                    endcase
                end
                S_WR: begin
                    if (!cpu_req) begin
                        up  <= cur;
                        cur <= dn;
                        if (row == LAST_ROW) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (row == PENULT_ROW) begin
                            // Old row 0 is already overwritten; use the saved copy.
                            dn  <= save0;
                            row <= row + ROW_ONE;
                        end else begin
                            row   <= row + ROW_ONE;
                            state <= S_RD_ISS;
                        end
                    end
                end
                S_DONE: begin
                    gen_count <= gen_count + GEN_ONE;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
